// File: rtl/rbus_arb_nto1_ctrl.sv
// Packet-level round-robin arbiter sharing one rbus output channel between N sources.
// Define RBUS_ARB_LOCK_EN to add i_lock, which lets a source keep the grant for up to 4 extra packets.
module rbus_arb_nto1_ctrl #(
  parameter int N       = 5,
  parameter int LEN_LSB = 64,
  parameter int LEN_W   = 4,
  parameter int GAP_TO  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [0:N-1]         i_req,
  output logic [0:N-1]         o_gnt,
  input  logic [0:N-1]         i_stb,
  input  logic [0:N-1]         i_sof,
  input  logic [0:N-1][71:0]   i_data,
`ifdef RBUS_ARB_LOCK_EN
  input  logic [0:N-1]         i_lock,
`endif
  output logic [0:N-1][1:0]    i_rdy,
  output logic [0:N-1][1:0]    i_rdyE,
  output logic                 o_stb,
  output logic                 o_sof,
  output logic [71:0]          o_data,
  input  logic [1:0]           o_rdy,
  input  logic [1:0]           o_rdyE,
  output logic [$clog2(N)-1:0] o_owner,
  output logic                 o_busy,
  output logic                 ff_err
);
  localparam int OW       = $clog2(N);
  localparam int GW       = $clog2(GAP_TO + 1);
  localparam int LOCK_MAX = 4;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_END} state_t;

  state_t           r_state;
  logic [0:N-1]     r_gnt;
  logic [OW-1:0]    r_owner;
  logic [OW-1:0]    r_ptr;
  logic             r_busy;
  logic             r_err;
  logic             r_stb;
  logic             r_sof;
  logic [71:0]      r_data;
  logic [LEN_W-1:0] r_rem;
  logic [GW-1:0]    r_gap;
`ifdef RBUS_ARB_LOCK_EN
  logic [2:0]       r_lock_cnt;
  logic             w_lock;
`endif

  logic [0:N-1]     w_illegal;
  logic [0:N-1]     w_req_hi;
  logic [0:N-1]     w_pick_oh;
  logic [OW-1:0]    w_pick;
  logic             w_pick_vld;
  logic             w_stb;
  logic             w_sof;
  logic [71:0]      w_data;
  logic [LEN_W-1:0] w_len;
  logic             w_last;
  logic             w_timeout;
  logic             w_keep;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_src
      // Only the grant holder ever sees downstream ready; everyone else is held off.
      assign i_rdy[gi]     = r_gnt[gi] ? o_rdy  : 2'b00;
      assign i_rdyE[gi]    = r_gnt[gi] ? o_rdyE : 2'b00;
      assign w_illegal[gi] = i_stb[gi] & ~r_gnt[gi];
      assign w_req_hi[gi]  = i_req[gi] & (OW'(gi) >= r_ptr);
      assign w_pick_oh[gi] = w_pick_vld & (w_pick == OW'(gi));
    end
  endgenerate

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    w_pick_vld = |i_req;
    w_pick     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_req[k]) w_pick = OW'(k);
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (w_req_hi[k]) w_pick = OW'(k);
    end
  end

  always_comb begin
    w_stb  = 1'b0;
    w_sof  = 1'b0;
    w_data = '0;
    for (int k = 0; k < N; k++) begin
      if (r_gnt[k]) begin
        w_stb  = i_stb[k];
        w_sof  = i_sof[k];
        w_data = i_data[k];
      end
    end
  end

  assign w_len     = w_data[LEN_LSB +: LEN_W];
  assign w_last    = w_stb &&
                     (((r_state == S_HDR) && w_sof && (w_len == '0)) ||
                      ((r_state == S_BODY) && (r_rem == LEN_W'(1))));
  assign w_timeout = ((r_state == S_HDR) || (r_state == S_BODY)) && !w_stb &&
                     (r_gap == GW'(GAP_TO - 1));

`ifdef RBUS_ARB_LOCK_EN
  always_comb begin
    w_lock = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (r_gnt[k]) w_lock = i_lock[k];
    end
  end
  assign w_keep = w_lock && (r_lock_cnt < 3'(LOCK_MAX));
`else
  assign w_keep = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_stb   <= 1'b0;
      r_sof   <= 1'b0;
      r_data  <= '0;
      r_rem   <= '0;
      r_gap   <= '0;
`ifdef RBUS_ARB_LOCK_EN
      r_lock_cnt <= '0;
`endif
    end else begin
      r_stb <= 1'b0;
      if (|w_illegal) r_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if ((o_rdy != 2'b00) && w_pick_vld) begin
            r_gnt   <= w_pick_oh;
            r_owner <= w_pick;
            r_busy  <= 1'b1;
            r_ptr   <= (w_pick == OW'(N - 1)) ? '0 : w_pick + 1'b1;
            r_gap   <= '0;
`ifdef RBUS_ARB_LOCK_EN
            r_lock_cnt <= '0;
`endif
            r_state <= S_HDR;
          end
        end
        S_HDR, S_BODY: begin
          if (w_stb) begin
            r_stb  <= 1'b1;
            r_sof  <= w_sof;
            r_data <= w_data;
            r_gap  <= '0;
            if (r_state == S_HDR) begin
              // A header without sof is flagged but still forwarded; keep waiting for a real header.
              if (!w_sof) begin
                r_err <= 1'b1;
              end else begin
                r_rem <= w_len;
                if (w_len != '0) r_state <= S_BODY;
              end
            end else begin
              if (w_sof) r_err <= 1'b1;
              r_rem <= r_rem - 1'b1;
            end
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      // Packet end or watchdog expiry overrides the per-state update above.
      if (w_timeout || (w_last && !w_keep)) begin
        if (w_timeout) r_err <= 1'b1;
        r_gnt   <= '0;
        r_busy  <= 1'b0;
        r_state <= S_END;
`ifdef RBUS_ARB_LOCK_EN
        r_lock_cnt <= '0;
`endif
      end else if (w_last) begin
        r_state <= S_HDR;
`ifdef RBUS_ARB_LOCK_EN
        r_lock_cnt <= r_lock_cnt + 1'b1;
`endif
      end
    end
  end

  assign o_gnt   = r_gnt;
  assign o_owner = r_owner;
  assign o_busy  = r_busy;
  assign o_stb   = r_stb;
  assign o_sof   = r_sof;
  assign o_data  = r_data;
  assign ff_err  = r_err;

endmodule

// File: tb/tb_rbus_arb_nto1_ctrl.sv
// Self-checking bench for rbus_arb_nto1_ctrl: directed steps with randomized packets and a
// transaction-level reference (round-robin pick by modular arithmetic, words expected one cycle later).
module tb_rbus_arb_nto1_ctrl;
  localparam int N       = 5;
  localparam int LEN_LSB = 64;
  localparam int LEN_W   = 4;
  localparam int GAP_TO  = 64;
  localparam int OW      = $clog2(N);

  logic               clk = 1'b0;
  logic               rst;
  logic [0:N-1]       i_req;
  logic [0:N-1]       o_gnt;
  logic [0:N-1]       i_stb;
  logic [0:N-1]       i_sof;
  logic [0:N-1][71:0] i_data;
`ifdef RBUS_ARB_LOCK_EN
  logic [0:N-1]       i_lock;
`endif
  logic [0:N-1][1:0]  i_rdy;
  logic [0:N-1][1:0]  i_rdyE;
  logic               o_stb;
  logic               o_sof;
  logic [71:0]        o_data;
  logic [1:0]         o_rdy;
  logic [1:0]         o_rdyE;
  logic [OW-1:0]      o_owner;
  logic               o_busy;
  logic               ff_err;

  int          n_cmp = 0;
  int          n_mis = 0;
  int          m_ptr = 0;
  logic [71:0] m_last = '0;

  always #5 clk = ~clk;

  rbus_arb_nto1_ctrl #(.N(N), .LEN_LSB(LEN_LSB), .LEN_W(LEN_W), .GAP_TO(GAP_TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .o_gnt   (o_gnt),
    .i_stb   (i_stb),
    .i_sof   (i_sof),
    .i_data  (i_data),
`ifdef RBUS_ARB_LOCK_EN
    .i_lock  (i_lock),
`endif
    .i_rdy   (i_rdy),
    .i_rdyE  (i_rdyE),
    .o_stb   (o_stb),
    .o_sof   (o_sof),
    .o_data  (o_data),
    .o_rdy   (o_rdy),
    .o_rdyE  (o_rdyE),
    .o_owner (o_owner),
    .o_busy  (o_busy),
    .ff_err  (ff_err)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:N-1] onehot(input int k);
    logic [0:N-1] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  // Reference arbitration: first requester at or after the pointer, modulo N.
  function automatic int model_pick(input logic [0:N-1] m, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (m[(ptr + i) % N]) return (ptr + i) % N;
    end
    return 0;
  endfunction

  task automatic do_reset();
    i_req = '0;
    i_stb = '0;
    i_sof = '0;
`ifdef RBUS_ARB_LOCK_EN
    i_lock = '0;
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_gnt", o_gnt, '0);
    chk("rst_stb", o_stb, 1'b0);
    chk("rst_sof", o_sof, 1'b0);
    chk("rst_data", o_data, '0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_owner", o_owner, '0);
    chk("rst_err", ff_err, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    m_ptr = 0;
    m_last = '0;
  endtask

  task automatic grant(input logic [0:N-1] m, input logic [1:0] rdy, input logic [1:0] rdyE,
                       input int lat, output int w);
    int k;
    logic [0:N-1] eg;
    i_req  = m;
    o_rdy  = rdy;
    o_rdyE = rdyE;
    for (k = 1; k <= 8; k++) begin
      tick();
      if (o_busy === 1'b1) break;
    end
    chk("grant_latency", k, lat);
    w = model_pick(m, m_ptr);
    m_ptr = (w + 1) % N;
    eg = onehot(w);
    chk("grant_vec", o_gnt, eg);
    chk("grant_owner", o_owner, w);
    for (int j = 0; j < N; j++) begin
      chk("rdy_fwd", i_rdy[j], (j == w) ? rdy : 2'b00);
      chk("rdyE_fwd", i_rdyE[j], (j == w) ? rdyE : 2'b00);
    end
  endtask

  task automatic do_packet(input int src, input int len, input int maxgap, input bit rel);
    logic [71:0] d;
    logic [0:N-1] eg;
    eg = onehot(src);
    for (int j = 0; j <= len; j++) begin
      int g;
      g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (g) begin
        tick();
        chk("gap_no_stb", o_stb, 1'b0);
        chk("gap_data_hold", o_data, m_last);
      end
      d = {8'($urandom), 32'($urandom), 32'($urandom)};
      if (j == 0) d[LEN_LSB +: LEN_W] = LEN_W'(len);
      i_stb = '0;
      i_sof = '0;
      i_stb[src]  = 1'b1;
      i_sof[src]  = (j == 0);
      i_data[src] = d;
      tick();
      i_stb = '0;
      i_sof = '0;
      m_last = d;
      chk("out_stb", o_stb, 1'b1);
      chk("out_sof", o_sof, (j == 0));
      chk("out_data", o_data, d);
      if (j == len && rel) begin
        chk("release_gnt", o_gnt, '0);
        chk("release_busy", o_busy, 1'b0);
        chk("release_rdy", i_rdy[src], 2'b00);
      end else begin
        chk("hold_gnt", o_gnt, eg);
        chk("hold_busy", o_busy, 1'b1);
      end
    end
  endtask

  initial begin
    int w;
    int order[6] = '{0, 1, 2, 3, 4, 0};
    logic [71:0] d;
    rst    = 1'b0;
    i_req  = '0;
    i_stb  = '0;
    i_sof  = '0;
    i_data = '0;
    o_rdy  = 2'b00;
    o_rdyE = 2'b00;
`ifdef RBUS_ARB_LOCK_EN
    i_lock = '0;
`endif
    do_reset();

    // Fairness: all requesting, single-word packets.
    for (int p = 0; p < 6; p++) begin
      grant('1, 2'b11, 2'b10, (p == 0) ? 1 : 2, w);
      chk("rr_order", o_owner, order[p]);
      do_packet(w, 0, 0, 1'b1);
    end

    // Basic grant of source 2 with a 4-word packet.
    do_reset();
    grant(onehot(2), 2'b11, 2'b11, 1, w);
    do_packet(2, 3, 0, 1'b1);
    chk("basic_err", ff_err, 1'b0);

    // Backpressure: no grant while downstream ready is zero.
    i_req = onehot(1);
    o_rdy = 2'b00;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_no_gnt", o_gnt, '0);
    end
    grant(onehot(1), 2'b01, 2'b00, 1, w);
    do_packet(1, 0, 0, 1'b1);

    // Random traffic; requests may change mid-packet without effect.
    for (int it = 0; it < 20; it++) begin
      logic [0:N-1] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      grant(m, 2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), 2, w);
      i_req = N'($urandom);
      do_packet(w, int'($urandom_range(0, 15)), 2, 1'b1);
    end
    chk("rand_no_err", ff_err, 1'b0);

    // Illegal strobe from a non-granted source.
    do_reset();
    grant(onehot(0), 2'b11, 2'b00, 1, w);
    i_stb[3] = 1'b1;
    i_sof[3] = 1'b1;
    i_data[3] = {8'($urandom), 32'($urandom), 32'($urandom)};
    tick();
    i_stb = '0;
    i_sof = '0;
    chk("illegal_dropped", o_stb, 1'b0);
    chk("illegal_err", ff_err, 1'b1);
    chk("illegal_gnt_kept", o_gnt, onehot(0));
    do_packet(0, 1, 0, 1'b1);
    chk("illegal_err_sticky", ff_err, 1'b1);

    // First granted word without sof.
    do_reset();
    grant(onehot(1), 2'b11, 2'b00, 1, w);
    d = {8'($urandom), 32'($urandom), 32'($urandom)};
    i_stb[1] = 1'b1;
    i_sof[1] = 1'b0;
    i_data[1] = d;
    tick();
    i_stb = '0;
    m_last = d;
    chk("nosof_fwd", o_stb, 1'b1);
    chk("nosof_sof", o_sof, 1'b0);
    chk("nosof_err", ff_err, 1'b1);
    chk("nosof_busy", o_busy, 1'b1);
    do_packet(1, 0, 0, 1'b1);

    // Gap watchdog: header of length 5, then silence.
    do_reset();
    grant(onehot(0) | onehot(2), 2'b11, 2'b00, 1, w);
    i_req = onehot(2);
    d = {8'($urandom), 32'($urandom), 32'($urandom)};
    d[LEN_LSB +: LEN_W] = LEN_W'(5);
    i_stb[0] = 1'b1;
    i_sof[0] = 1'b1;
    i_data[0] = d;
    tick();
    i_stb = '0;
    i_sof = '0;
    m_last = d;
    chk("to_hdr_stb", o_stb, 1'b1);
    for (int c = 1; c <= GAP_TO; c++) begin
      tick();
      if (c == GAP_TO - 1) begin
        chk("to_still_busy", o_busy, 1'b1);
        chk("to_no_err_yet", ff_err, 1'b0);
      end
    end
    chk("to_gnt_revoked", o_gnt, '0);
    chk("to_err", ff_err, 1'b1);
    chk("to_busy", o_busy, 1'b0);
    grant(onehot(2), 2'b11, 2'b00, 2, w);
    chk("to_next_owner", o_owner, 2);
    do_packet(2, 0, 0, 1'b1);

`ifdef RBUS_ARB_LOCK_EN
    // Locked source keeps the grant for 5 packets, then the next requester wins.
    do_reset();
    i_lock = onehot(0);
    grant('1, 2'b11, 2'b00, 1, w);
    for (int p = 0; p < 5; p++) begin
      do_packet(0, int'($urandom_range(0, 2)), 1, (p == 4));
    end
    i_lock = '0;
    grant('1, 2'b11, 2'b00, 2, w);
    chk("lock_next_owner", o_owner, 1);
    do_packet(w, 0, 0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rbus_arb_nto1_ctrl.md
Name: rbus_arb_nto1_ctrl

Overview:
- Packet-level round-robin arbiter and sequencer that shares one rbus output channel between N requesting rbus sources.
- Sources raise a request, receive a grant, then stream exactly one packet. Only the granted source sees the downstream ready, so non-granted sources are held off.
- Sits in front of an rbus mux/demux fabric output stage; replaces blind N-to-1 merging where packet ordering and fairness must be controlled.

Parameters:
- N, 5, number of requesting input channels (2..16).
- LEN_LSB, 64, bit position of the payload-length field in the sof word.
- LEN_W, 4, width of the payload-length field; packet length = 1 + field value words.
- GAP_TO, 64, maximum idle cycles allowed between words of a granted packet.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- i_req  input  [0:N-1]x1  level request per source.
- o_gnt  output  [0:N-1]x1  one-hot grant.
- i_stb  input  [0:N-1]x1  word strobe.
- i_sof  input  [0:N-1]x1  start of frame.
- i_data  input  [0:N-1]x72  word data.
- i_rdy  output  [0:N-1]x2  ready, forwarded to granted source only.
- i_rdyE  output  [0:N-1]x2  ready-E, forwarded to granted source only.
- o_stb  output  1  registered output strobe.
- o_sof  output  1  registered output sof.
- o_data  output  72  registered output data.
- o_rdy  input  2  downstream ready.
- o_rdyE  input  2  downstream ready-E.
- o_owner  output  $clog2(N)  index of current grant holder (valid while o_busy=1).
- o_busy  output  1  grant active.
- ff_err  output  1  sticky protocol error.

Behaviour:
- Reset (rst=0, asynchronous): o_gnt=0, o_stb=0, o_sof=0, o_data=0, o_busy=0, o_owner=0, ff_err=0, RR pointer=0, state=IDLE. Reset mid-packet abandons the packet silently.
- State IDLE:
  - If o_rdy!=0 and any i_req is set, pick the first requester at or after the pointer, wrapping modulo N.
  - Next cycle: o_gnt[w]=1, o_owner=w, o_busy=1, pointer=(w+1) mod N, state HDR.
  - Grant latency is 1 cycle from request. If o_rdy==0, no grant is issued.
- Ready forwarding (combinational): i_rdy[w]=o_rdy and i_rdyE[w]=o_rdyE for the granted w. All other i_rdy/i_rdyE=0. In IDLE all are 0.
- State HDR (waiting for the first word):
  - On i_stb[w]: forward the word.
  - If i_sof[w]=0: set ff_err and stay in HDR.
  - Else load remaining = i_data[w][LEN_LSB+LEN_W-1:LEN_LSB]. If remaining==0, go to END; otherwise go to BODY.
- State BODY: each i_stb[w] forwards a word and decrements remaining; on remaining reaching 0, go to END. i_sof[w]=1 in BODY sets ff_err; the word is still forwarded and counted.
- State END: o_gnt=0, o_busy=0. Next cycle returns to IDLE. The minimum gap between consecutive grants is therefore 2 cycles.
- Output pipeline:
  - o_stb/o_sof/o_data are registered copies of the granted input, giving 1 cycle latency.
  - o_stb=0 when no word is forwarded. o_data holds its last value when o_stb=0.
- Gap watchdog:
  - The counter resets on every forwarded word and counts cycles in HDR/BODY without i_stb[w].
  - On reaching GAP_TO: set ff_err, go to END (grant revoked).
- Illegal strobe: i_stb[k]=1 for any k not granted (including in IDLE/END) sets ff_err; the word is dropped and never reaches the output.
- Requester dropping i_req mid-packet has no effect; the grant is held until the packet end or timeout.
- ff_err is sticky until reset.

Optional Feature:
- Macro RBUS_ARB_LOCK_EN.
- When defined:
  - Adds input i_lock [0:N-1]x1.
  - If i_lock[w]=1 on the cycle the last word is accepted, the controller skips END and returns to HDR with the grant kept. The pointer is not advanced.
  - At most 4 consecutive locked packets are allowed; the 5th packet end releases unconditionally.
- When undefined: the i_lock port does not exist and every packet end releases the grant.

Test Plan:
- Basic grant: o_rdy=2'b11, i_req[2]=1 at cycle 0 -> o_gnt[2]=1 at cycle 1. Sof word with length field 3, then 4 words -> o_stb high for 4 cycles starting 1 cycle after each input word; o_gnt=0 after the last word; ff_err=0.
- Round-robin fairness: i_req=all ones held, N=5, every packet single-word (length 0) -> grant order 0,1,2,3,4,0. No source is granted twice before all others have been granted.
- Backpressure: o_rdy=0 with i_req[1]=1 -> no grant. o_rdy=2'b01 at cycle 10 -> o_gnt[1] at cycle 11, i_rdy[1]=2'b01, all other i_rdy=0.
- Protocol errors:
  - i_stb[3]=1 while source 0 is granted -> word not output, ff_err=1 from the next cycle, held until rst=0.
  - First granted word with sof=0 -> ff_err=1.
- Gap timeout: GAP_TO=64, granted source sends the header (length 5) then stops -> 64 cycles later o_gnt=0, ff_err=1, and the next requester is granted 2 cycles after release.
- Lock (RBUS_ARB_LOCK_EN): i_lock[0]=1 held, i_req=all ones -> source 0 holds the grant for 5 packets, then source 1 is granted.
